// File: rtl/fp_addsub_seq_unit.sv
// Multi-cycle IEEE-754 binary32 add/subtract engine with valid/ready handshakes.
// Fixed pipeline of FSM states (UNPACK, ALIGN, ADD, NORM, ROUND) then DONE until the result is taken.
module fp_addsub_seq_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_invalid,
  output logic             flag_overflow,
  output logic             flag_underflow
);

  localparam int unsigned SIG_W = MANT_W + 1;        // significand with hidden bit
  localparam int unsigned EXT_W = SIG_W + 3;         // plus guard, round, sticky
  localparam int unsigned SUM_W = EXT_W + 1;         // plus carry out
  localparam int unsigned SE_W  = EXP_W + 2;         // working exponent, MSB flags negative
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);
  localparam int unsigned RND_W = SIG_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MANT_W-1){1'b0}}};

  // Only binary32 is implemented
  if (WIDTH != 32 || EXP_W != 8 || MANT_W != 23) begin : g_bad_cfg
    $error("fp_addsub_seq_unit: only binary32 (32/8/23) is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_next;
  logic   accept;

  // Latched operands
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;

  // UNPACK stage registers
  logic             sa_q, sb_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [SIG_W-1:0] ma_q, mb_q;
  logic             spec_q, spec_inv_q;
  logic [WIDTH-1:0] spec_res_q;

  // ALIGN / ADD / NORM stage registers
  logic             sign_q, sub_q;
  logic [SE_W-1:0]  exp_q;
  logic [EXT_W-1:0] big_q, small_q;
  logic [SUM_W-1:0] sum_q;
  logic [EXT_W-1:0] norm_q;
  logic [SE_W-1:0]  nexp_q;
  logic             nsign_q, nzero_q, nuf_q;

  // Field views of the latched operands; B's sign folds in the operation
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MANT_W-1:0] a_man, b_man;
  assign a_sign = a_q[WIDTH-1];
  assign b_sign = b_q[WIDTH-1] ^ ~op_q;
  assign a_exp  = a_q[WIDTH-2 -: EXP_W];
  assign b_exp  = b_q[WIDTH-2 -: EXP_W];
  assign a_man  = a_q[MANT_W-1:0];
  assign b_man  = b_q[MANT_W-1:0];

  // UNPACK: special-case classification and subnormal flush
  logic             u_spec, u_inv;
  logic [WIDTH-1:0] u_res;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  always_comb begin
    a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
    b_nan  = (b_exp == EXP_MAX) && (b_man != '0);
    a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
    b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    u_spec = 1'b1;
    u_inv  = 1'b0;
    u_res  = '0;
    if (a_nan || b_nan) begin
      u_res = QNAN;
      u_inv = 1'b1;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      u_res = QNAN;
      u_inv = 1'b1;
    end else if (a_inf) begin
      u_res = {a_sign, EXP_MAX, {MANT_W{1'b0}}};
    end else if (b_inf) begin
      u_res = {b_sign, EXP_MAX, {MANT_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      u_res = {a_sign & b_sign, {(WIDTH-1){1'b0}}};
    end else begin
      u_spec = 1'b0;
    end
  end

  // ALIGN: order by magnitude, shift the smaller significand with sticky collection
  logic             a_ge;
  logic [EXP_W-1:0] big_e, small_e, diff, sh;
  logic [SIG_W-1:0] big_m, small_m;
  logic [2*EXT_W-1:0] wide;
  logic [EXT_W-1:0] al_small;
  always_comb begin
    a_ge    = {ea_q, ma_q} >= {eb_q, mb_q};
    big_e   = a_ge ? ea_q : eb_q;
    small_e = a_ge ? eb_q : ea_q;
    big_m   = a_ge ? ma_q : mb_q;
    small_m = a_ge ? mb_q : ma_q;
    diff    = big_e - small_e;
    sh      = (diff > EXP_W'(EXT_W)) ? EXP_W'(EXT_W) : diff;
    wide    = {small_m, 3'b000, {EXT_W{1'b0}}} >> sh;
    al_small = {wide[2*EXT_W-1 -: EXT_W-1], wide[EXT_W] | (|wide[EXT_W-1:0])};
  end

  // ADD: magnitude add or subtract; big >= small so the difference is non-negative
  logic [SUM_W-1:0] add_sum;
  always_comb begin
    if (sub_q) add_sum = {1'b0, big_q} - {1'b0, small_q};
    else       add_sum = {1'b0, big_q} + {1'b0, small_q};
  end

  // NORM: carry right-shift or leading-zero left-shift, flush on exponent underflow
  logic [LZ_W-1:0]  lz;
  logic [EXT_W-1:0] n_sig;
  logic [SE_W-1:0]  n_exp;
  logic             n_zero, n_uf;
  always_comb begin
    lz = LZ_W'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (sum_q[i]) lz = LZ_W'(int'(EXT_W) - 1 - i);
    end
    if (sum_q[EXT_W]) begin
      n_sig = {sum_q[EXT_W:2], sum_q[1] | sum_q[0]};
      n_exp = exp_q + SE_W'(1);
    end else begin
      n_sig = sum_q[EXT_W-1:0] << lz;
      n_exp = exp_q - SE_W'(lz);
    end
    n_zero = (sum_q == '0);
    n_uf   = !n_zero && (n_exp[SE_W-1] || (n_exp == '0));
  end

  // ROUND: nearest-even, renormalise on mantissa carry, saturate to infinity
  logic             rup;
  logic [RND_W-1:0] m_r;
  logic [SE_W-1:0]  r_exp;
  logic [MANT_W-1:0] frac;
  logic [WIDTH-1:0] r_res;
  logic             r_inv, r_ovf, r_uf;
  always_comb begin
    rup   = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    m_r   = {1'b0, norm_q[EXT_W-1:3]} + RND_W'(rup);
    r_exp = m_r[SIG_W] ? nexp_q + SE_W'(1) : nexp_q;
    frac  = m_r[SIG_W] ? m_r[MANT_W:1] : m_r[MANT_W-1:0];
    r_inv = 1'b0;
    r_ovf = 1'b0;
    r_uf  = 1'b0;
    if (spec_q) begin
      r_res = spec_res_q;
      r_inv = spec_inv_q;
    end else if (nzero_q) begin
      r_res = '0;
    end else if (nuf_q) begin
      r_res = {nsign_q, {(WIDTH-1){1'b0}}};
      r_uf  = 1'b1;
    end else if (r_exp >= SE_W'(EXP_MAX)) begin
      r_res = {nsign_q, EXP_MAX, {MANT_W{1'b0}}};
      r_ovf = 1'b1;
    end else begin
      r_res = {nsign_q, r_exp[EXP_W-1:0], frac};
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE:   if (in_valid) begin
                  state_next = S_UNPACK;
                  accept     = 1'b1;
                end
      S_UNPACK: state_next = S_ALIGN;
      S_ALIGN:  state_next = S_ADD;
      S_ADD:    state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State, handshake outputs, result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      result         <= '0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      if (accept) begin
        result         <= '0;
        flag_invalid   <= 1'b0;
        flag_overflow  <= 1'b0;
        flag_underflow <= 1'b0;
      end else if (state == S_ROUND) begin
        result         <= r_res;
        flag_invalid   <= r_inv;
        flag_overflow  <= r_ovf;
        flag_underflow <= r_uf;
      end
    end
  end

  // Datapath stage registers, each loaded in its own state
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= operation_select;
    end
    if (state == S_UNPACK) begin
      sa_q       <= a_sign;
      sb_q       <= b_sign;
      ea_q       <= a_exp;
      eb_q       <= b_exp;
      ma_q       <= a_zero ? '0 : {1'b1, a_man};
      mb_q       <= b_zero ? '0 : {1'b1, b_man};
      spec_q     <= u_spec;
      spec_inv_q <= u_inv;
      spec_res_q <= u_res;
    end
    if (state == S_ALIGN) begin
      sign_q  <= a_ge ? sa_q : sb_q;
      sub_q   <= sa_q ^ sb_q;
      exp_q   <= SE_W'(big_e);
      big_q   <= {big_m, 3'b000};
      small_q <= al_small;
    end
    if (state == S_ADD) begin
      sum_q <= add_sum;
    end
    if (state == S_NORM) begin
      norm_q  <= n_sig;
      nexp_q  <= n_exp;
      nsign_q <= sign_q;
      nzero_q <= n_zero;
      nuf_q   <= n_uf;
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq_unit.sv
// Directed bench for fp_addsub_seq_unit: latency, arithmetic, specials, backpressure, reset.
module tb_fp_addsub_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        operation_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_invalid, flag_overflow, flag_underflow;

  int checks = 0;
  int errors = 0;

  fp_addsub_seq_unit #(.WIDTH(32), .EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation_select(operation_select),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_underflow(flag_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair and wait (bounded) for out_valid; returns edges after accept
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                        input string tag, output int lat);
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; operation_select = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd0);
    chk({tag, ".flags_clear"}, {29'd0, flag_invalid, flag_overflow, flag_underflow}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full transaction with out_ready held high; result consumed on the following edge
  task automatic txn(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                     input logic [31:0] er, input logic ei, input logic eo, input logic eu,
                     input string tag);
    int lat;
    launch(ta, tb_, top, tag, lat);
    // out_valid occupies the 6th cycle after the accept edge: seen after the 5th later edge
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".result"}, result, er);
    chk({tag, ".flags"}, {29'd0, flag_invalid, flag_overflow, flag_underflow},
        {29'd0, ei, eo, eu});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; operation_select = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.flags", {29'd0, flag_invalid, flag_overflow, flag_underflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //  a            b            op  result       inv ovf uf
    txn(32'h3F800000, 32'h40000000, 1, 32'h40400000, 0, 0, 0, "one_plus_two");
    txn(32'h7F7FFFFF, 32'h7F7FFFFF, 1, 32'h7F800000, 0, 1, 0, "max_overflow");
    txn(32'h7F800000, 32'h7F800000, 0, 32'h7FC00000, 1, 0, 0, "inf_minus_inf");
    txn(32'h3F800000, 32'h33800000, 1, 32'h3F800000, 0, 0, 0, "tie_even_down");
    txn(32'h3F800001, 32'h33800000, 1, 32'h3F800002, 0, 0, 0, "tie_even_up");
    txn(32'h40490FDB, 32'h40490FDB, 0, 32'h00000000, 0, 0, 0, "cancel_pos_zero");
    txn(32'h80000000, 32'h80000000, 1, 32'h80000000, 0, 0, 0, "neg_zero_sum");
    txn(32'h00000000, 32'h80000000, 1, 32'h00000000, 0, 0, 0, "pos_plus_neg_zero");
    txn(32'h3FC00000, 32'h3F800000, 0, 32'h3F000000, 0, 0, 0, "sub_normalise");
    txn(32'h00800000, 32'h00800001, 0, 32'h80000000, 0, 0, 1, "underflow_flush");
    txn(32'hFF800000, 32'h3F800000, 1, 32'hFF800000, 0, 0, 0, "neg_inf_finite");
    txn(32'h3F800000, 32'hFFC12345, 1, 32'h7FC00000, 1, 0, 0, "nan_input");
    txn(32'h00000001, 32'h3F800000, 1, 32'h3F800000, 0, 0, 0, "subnormal_flush");

    // Backpressure: hold the result for 10 cycles while new operands are offered
    out_ready = 1'b0;
    launch(32'h3F800000, 32'h40000000, 1, "bp", lat);
    chk("bp.latency", 32'(lat), 32'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h7F800000; b = 32'h7F800000; operation_select = 1'b0;
      @(posedge clk);
      #1;
      chk("bp.hold_result", result, 32'h40400000);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp.hold_flags", {29'd0, flag_invalid, flag_overflow, flag_underflow}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("bp.no_ghost_txn", 32'(out_valid), 32'd0);

    // Reset three cycles after accept discards the transaction
    launch_reset: begin
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40000000; operation_select = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
      chk("rst_mid.result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_mid.discarded", 32'(out_valid), 32'd0);
    end
    txn(32'h40000000, 32'h3F800000, 0, 32'h3F800000, 0, 0, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
